// File: rtl/avmm_burst_slave_ram_pkg.sv
// Shared types and constants for the Avalon-MM burst slave RAM.
package avmm_burst_pkg;

   localparam int AVMM_DATA_W = 32;
   localparam int AVMM_ADDR_W = 32;
   localparam int BC_W        = 7;

   localparam logic [BC_W-1:0] BURST_LEN = 7'd64;

   typedef enum logic [1:0] {
      IDLE,
      WR_BURST,
      RD_DELAY,
      RD_DATA
   } state_t;

   // A burstcount of zero is serviced as a single beat.
   function automatic logic [BC_W-1:0] eff_burst(input logic [BC_W-1:0] bc);
      return (bc == '0) ? BC_W'(1) : bc;
   endfunction

endpackage

// File: rtl/avmm_burst_slave_ram_if.sv
// Avalon-MM burst bus between the LPDDR burst master and the RAM responder.
interface avmm_burst_slave_ram_if;
   import avmm_burst_pkg::*;

   logic [AVMM_ADDR_W-1:0] address;
   logic [BC_W-1:0]        burstcount;
   logic                   write;
   logic [AVMM_DATA_W-1:0] writedata;
   logic                   read;
   logic                   waitrequest;
   logic [AVMM_DATA_W-1:0] readdata;
   logic                   readdatavalid;

   modport slave (
      input  address, burstcount, write, writedata, read,
      output waitrequest, readdata, readdatavalid
   );

   modport master (
      output address, burstcount, write, writedata, read,
      input  waitrequest, readdata, readdatavalid
   );

endinterface

// File: rtl/avmm_burst_slave_ram_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered (1-cycle) read port.
module avmm_sdp_ram #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Write port.
   // NOTE: the storage array is deliberately not reset so it maps onto block RAM; only the output register is.
   // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Registered read port; holds the last read word between reads.
   always_ff @(posedge clk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/avmm_burst_slave_ram.sv
// Avalon-MM burst slave backed by on-chip RAM, with fixed read latency and
// periodic waitrequest stall injection on write beats.
module avmm_burst_slave_ram
   import avmm_burst_pkg::*;
#(
   parameter int ADDR_W       = 10,
   parameter int READ_LATENCY = 2,
   parameter int STALL_PERIOD = 0
) (
   input  logic                   avmm_s_clk,
   input  logic                   avmm_s_rst,
   avmm_burst_slave_ram_if.slave  avmm_s,
   output logic                   err_burstcount
);

   // The RAM read is issued one cycle before its readdatavalid, so RD_DELAY
   // issues on its last cycle; a latency of 1 issues straight from IDLE.
   localparam logic [7:0] DLY_INIT = (READ_LATENCY >= 2) ? 8'(READ_LATENCY - 2) : 8'd0;
   localparam bit         LAT1     = (READ_LATENCY == 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BC_W-1:0]   rem_q, rem_d;
   logic [7:0]        dly_q, dly_d;
   logic [15:0]       beat_q;
   logic              stall_q, rdv_q, err_q;

   logic              wait_req, wr_acc, rd_acc;
   logic [ADDR_W-1:0] cmd_addr;
   logic [BC_W-1:0]   cmd_bc;
   logic              ram_we, ram_re;
   logic [ADDR_W-1:0] ram_waddr, ram_raddr;
   logic              unused_addr_bits;

   assign cmd_addr         = avmm_s.address[ADDR_W+1:2];
   assign cmd_bc           = eff_burst(avmm_s.burstcount);
   assign unused_addr_bits = ^{avmm_s.address[AVMM_ADDR_W-1:ADDR_W+2], avmm_s.address[1:0]};

   assign wait_req = avmm_s_rst || (state_q == RD_DELAY) || (state_q == RD_DATA) || stall_q;
   assign wr_acc   = avmm_s.write && !wait_req;
   assign rd_acc   = avmm_s.read && !avmm_s.write && !wait_req && (state_q == IDLE);

   assign avmm_s.waitrequest   = wait_req;
   assign avmm_s.readdatavalid = rdv_q && !avmm_s_rst;
   assign err_burstcount       = err_q;

   // Next-state, counter updates and RAM port control.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      dly_d     = dly_q;
      ram_we    = 1'b0;
      ram_waddr = addr_q;
      ram_re    = 1'b0;
      ram_raddr = addr_q;
      case (state_q)
         IDLE: begin
            if (wr_acc) begin
               ram_we    = 1'b1;
               ram_waddr = cmd_addr;
               addr_d    = cmd_addr + 1'b1;
               rem_d     = cmd_bc - 1'b1;
               state_d   = (cmd_bc == BC_W'(1)) ? IDLE : WR_BURST;
            end else if (rd_acc) begin
               addr_d  = cmd_addr;
               rem_d   = cmd_bc;
               dly_d   = DLY_INIT;
               state_d = RD_DELAY;
               if (LAT1) begin
                  ram_re    = 1'b1;
                  ram_raddr = cmd_addr;
                  addr_d    = cmd_addr + 1'b1;
                  rem_d     = cmd_bc - 1'b1;
                  state_d   = RD_DATA;
               end
            end
         end
         WR_BURST: begin
            if (wr_acc) begin
               ram_we = 1'b1;
               addr_d = addr_q + 1'b1;
               rem_d  = rem_q - 1'b1;
               if (rem_q == BC_W'(1)) state_d = IDLE;
            end
         end
         RD_DELAY: begin
            if (dly_q == 8'd0) begin
               ram_re  = 1'b1;
               addr_d  = addr_q + 1'b1;
               rem_d   = rem_q - 1'b1;
               state_d = RD_DATA;
            end else begin
               dly_d = dly_q - 1'b1;
            end
         end
         RD_DATA: begin
            // Stay until the cycle carrying the last readdatavalid has passed.
            if (rem_q != '0) begin
               ram_re = 1'b1;
               addr_d = addr_q + 1'b1;
               rem_d  = rem_q - 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counters, stall injection, read-valid pipeline and sticky error.
   always_ff @(posedge avmm_s_clk) begin
      if (avmm_s_rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         dly_q   <= '0;
         beat_q  <= '0;
         stall_q <= 1'b0;
         rdv_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         dly_q   <= dly_d;
         rdv_q   <= ram_re;
         stall_q <= 1'b0;
         if (STALL_PERIOD != 0 && wr_acc) begin
            if (beat_q == 16'(STALL_PERIOD - 1)) begin
               beat_q  <= '0;
               stall_q <= 1'b1;
            end else begin
               beat_q <= beat_q + 1'b1;
            end
         end
         if (((wr_acc && state_q == IDLE) || rd_acc) && avmm_s.burstcount == '0)
            err_q <= 1'b1;
      end
   end

   avmm_sdp_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (AVMM_DATA_W)
   ) u_ram (
      .clk   (avmm_s_clk),
      .rst   (avmm_s_rst),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (avmm_s.writedata),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdata (avmm_s.readdata)
   );

endmodule

// File: tb/tb_avmm_burst_slave_ram.sv
// Self-checking bench for avmm_burst_slave_ram (READ_LATENCY=2, STALL_PERIOD=8).
module tb_avmm_burst_slave_ram;
   import avmm_burst_pkg::*;

   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic err;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [31:0] ref_mem [1024];

   avmm_burst_slave_ram_if bus ();

   avmm_burst_slave_ram #(
      .ADDR_W       (10),
      .READ_LATENCY (LAT),
      .STALL_PERIOD (8)
   ) dut (
      .avmm_s_clk     (clk),
      .avmm_s_rst     (rst),
      .avmm_s         (bus),
      .err_burstcount (err)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   typedef struct {
      logic [31:0] addr;
      logic [6:0]  bc;
      logic [31:0] base;
      logic [9:0]  exp_w0;
      int          exp_beats;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Drives a write burst honouring waitrequest; later beats carry junk address/burstcount.
   task automatic write_burst(input logic [31:0] addr, input logic [6:0] bc, input logic [9:0] w0,
                              input logic [31:0] base, input bit hold_read,
                              output int n_stall, output bit stall_pos_ok, output bit post_wait);
      int beats = (bc == 7'd0) ? 1 : int'(bc);
      int i = 0;
      int guard = 0;
      n_stall = 0;
      stall_pos_ok = 1'b1;
      while (i < beats && guard < 1000) begin
         @(negedge clk);
         guard++;
         bus.write      = 1'b1;
         bus.read       = hold_read;
         bus.writedata  = base + 32'(i);
         bus.address    = (i == 0) ? addr : 32'hDEAD_BEEC;
         bus.burstcount = (i == 0) ? bc : 7'd99;
         if (bus.waitrequest) begin
            if (i > 0) begin
               n_stall++;
               if (i % 8 != 0) stall_pos_ok = 1'b0;
            end
         end else begin
            ref_mem[w0 + 10'(i)] = base + 32'(i);
            i++;
         end
      end
      if (i < beats) check("wr_timeout", 32'(i), 32'(beats));
      @(negedge clk);
      bus.write = 1'b0;
      bus.read  = hold_read;
      post_wait = bus.waitrequest;
   endtask

   // Presents a read command and returns at the negedge before its accept edge.
   task automatic read_issue(input logic [31:0] addr, input logic [6:0] bc);
      int g = 0;
      @(negedge clk);
      bus.read       = 1'b1;
      bus.address    = addr;
      bus.burstcount = bc;
      while (bus.waitrequest && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (g >= 200) check("rd_accept_timeout", 32'(g), 32'd0);
   endtask

   // Measures latency from the accept edge, then checks every returned beat.
   task automatic read_collect(input logic [9:0] w0, input int exp_beats, input string tag);
      int n = 0;
      int k = 0;
      int extra = 0;
      while (n < 40) begin
         @(negedge clk);
         bus.read = 1'b0;
         n++;
         if (bus.readdatavalid) break;
      end
      check({tag, "_latency"}, 32'(n), 32'(LAT));
      while (bus.readdatavalid && k < 200) begin
         check({tag, "_data"}, bus.readdata, ref_mem[w0 + 10'(k)]);
         k++;
         @(negedge clk);
      end
      check({tag, "_free_after_last"}, 32'(bus.waitrequest), 32'd0);
      repeat (3) begin
         if (bus.readdatavalid) extra++;
         @(negedge clk);
      end
      check({tag, "_beats"}, 32'(k), 32'(exp_beats));
      check({tag, "_extra_valids"}, 32'(extra), 32'd0);
   endtask

   initial begin
      vec_t vecs [5];
      int   n_stall;
      bit   pos_ok;
      bit   post_wait;

      vecs[0] = '{32'h0000_0100, 7'd64,  32'hA500_0000, 10'h040, 64};
      vecs[1] = '{32'h0000_0FF8, 7'd4,   32'h3C00_0000, 10'h3FE, 4};
      vecs[2] = '{32'h0000_0200, 7'd1,   32'h1111_0000, 10'h080, 1};
      vecs[3] = '{32'h1234_0A04, 7'd3,   32'h6600_0000, 10'h281, 3};
      vecs[4] = '{32'h0000_07FC, 7'd127, 32'h7700_0000, 10'h1FF, 127};

      bus.write = 1'b0; bus.read = 1'b0; bus.address = '0;
      bus.burstcount = '0; bus.writedata = '0;

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_waitrequest", 32'(bus.waitrequest), 32'd1);
      check("rst_readdatavalid", 32'(bus.readdatavalid), 32'd0);
      check("rst_readdata", bus.readdata, 32'd0);
      check("rst_err", 32'(err), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_waitrequest", 32'(bus.waitrequest), 32'd0);

      // Stall injection: one wait cycle after every 8th beat, including the last.
      write_burst(32'h0000_0400, 7'd64, 10'h100, 32'h5A00_0000, 1'b0, n_stall, pos_ok, post_wait);
      check("stall_count", 32'(n_stall), 32'd7);
      check("stall_positions", 32'(pos_ok), 32'd1);
      check("stall_after_beat64", 32'(post_wait), 32'd1);
      read_issue(32'h0000_0400, 7'd64);
      read_collect(10'h100, 64, "stall_rb");

      // Table of write-then-readback bursts (nominal, wrap, single, upper bits, max).
      for (int v = 0; v < 5; v++) begin
         write_burst(vecs[v].addr, vecs[v].bc, vecs[v].exp_w0, vecs[v].base, 1'b0,
                     n_stall, pos_ok, post_wait);
         read_issue(vecs[v].addr, vecs[v].bc);
         read_collect(vecs[v].exp_w0, vecs[v].exp_beats, $sformatf("vec%0d", v));
      end
      check("err_clean", 32'(err), 32'd0);

      // write and read together in IDLE: write burst first, read right after.
      do_reset();
      write_burst(32'h0000_0800, 7'd4, 10'h200, 32'h4400_0000, 1'b1, n_stall, pos_ok, post_wait);
      bus.address    = 32'h0000_0800;
      bus.burstcount = 7'd4;
      check("wr_rd_no_early_valid", 32'(bus.readdatavalid), 32'd0);
      check("wr_rd_read_accept_next", 32'(post_wait), 32'd0);
      read_collect(10'h200, 4, "wr_rd");

      // Reset in the middle of a 64-beat read, after beat 10.
      begin
         int n = 0;
         int k = 0;
         int late = 0;
         read_issue(32'h0000_0100, 7'd64);
         while (n < 40) begin
            @(negedge clk);
            bus.read = 1'b0;
            n++;
            if (bus.readdatavalid) break;
         end
         while (bus.readdatavalid && k < 10) begin
            check("abort_data", bus.readdata, ref_mem[10'h040 + 10'(k)]);
            k++;
            if (k < 10) @(negedge clk);
         end
         check("abort_beats_before", 32'(k), 32'd10);
         @(negedge clk);
         rst = 1'b1;
         #1;
         check("abort_rdv_drop", 32'(bus.readdatavalid), 32'd0);
         check("abort_wait_in_rst", 32'(bus.waitrequest), 32'd1);
         @(negedge clk);
         check("abort_rdv_held", 32'(bus.readdatavalid), 32'd0);
         rst = 1'b0;
         repeat (4) begin
            @(negedge clk);
            if (bus.readdatavalid) late++;
         end
         check("abort_no_more_beats", 32'(late), 32'd0);
         check("abort_idle", 32'(bus.waitrequest), 32'd0);
         read_issue(32'h0000_0120, 7'd8);
         read_collect(10'h048, 8, "post_abort");
      end

      // burstcount==0 read: one beat, sticky error until reset.
      read_issue(32'h0000_0100, 7'd0);
      read_collect(10'h040, 1, "bc0");
      check("bc0_err_set", 32'(err), 32'd1);
      write_burst(32'h0000_0900, 7'd2, 10'h240, 32'h9900_0000, 1'b0, n_stall, pos_ok, post_wait);
      read_issue(32'h0000_0900, 7'd2);
      read_collect(10'h240, 2, "bc0_after");
      check("bc0_err_sticky", 32'(err), 32'd1);
      do_reset();
      check("bc0_err_cleared", 32'(err), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
